// File: rtl/packed_satadd_pipe.sv
// Two-stage packed-SIMD add/subtract with per-lane saturate-or-wrap and sticky overflow.
// Stage 1 holds the operands; stage 2 holds the lane results that drive the output stream.
module packed_satadd_pipe #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   a,
  input  logic [LANES*LANE_W-1:0]   b,
  input  logic                      op_sub,
  input  logic                      sat_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   result,
  output logic [LANES-1:0]          lane_ovf,
  output logic [LANES-1:0]          sticky_ovf,
  input  logic                      sticky_clr
);

  localparam int W   = LANES * LANE_W;
  localparam int MSB = LANE_W - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s1_sub_q, s1_sub_d;
  logic             s1_sat_q, s1_sat_d;

  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     result_q, result_d;
  logic [LANES-1:0] lane_ovf_q, lane_ovf_d;
  logic [LANES-1:0] sticky_q, sticky_d;

  logic             advance;
  logic             s2_load;
  logic [W-1:0]     lane_res;
  logic [LANES-1:0] lane_ovf_c;

  // Each lane is an isolated LANE_W-bit adder; subtract is A + ~B + 1 so B = most-negative needs no special case.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lbp;
    logic [LANE_W-1:0] ls;
    logic              lovf;

    assign la   = s1_a_q[i*LANE_W +: LANE_W];
    assign lbp  = s1_sub_q ? ~s1_b_q[i*LANE_W +: LANE_W] : s1_b_q[i*LANE_W +: LANE_W];
    assign ls   = la + lbp + {{MSB{1'b0}}, s1_sub_q};
    assign lovf = (la[MSB] == lbp[MSB]) & (ls[MSB] != la[MSB]);

    assign lane_ovf_c[i] = lovf;
    assign lane_res[i*LANE_W +: LANE_W] =
      (lovf & s1_sat_q) ? (la[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}}) : ls;
  end

  // One advance signal moves both stages, so an empty S1 still waits behind a stalled S2.
  always_comb begin
    advance    = ~s2_valid_q | out_ready;
    s2_load    = advance & s1_valid_q;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_sub_d   = s1_sub_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    lane_ovf_d = lane_ovf_q;

    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_a_d   = a;
        s1_b_d   = b;
        s1_sub_d = op_sub;
        s1_sat_d = sat_en;
      end
      if (s1_valid_q) begin
        result_d   = lane_res;
        lane_ovf_d = lane_ovf_c;
      end
    end

    sticky_d = (sticky_clr ? '0 : sticky_q) | (s2_load ? lane_ovf_c : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sub_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      lane_ovf_q <= '0;
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_sub_q   <= s1_sub_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      lane_ovf_q <= lane_ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready   = advance;
  assign out_valid  = s2_valid_q;
  assign result     = result_q;
  assign lane_ovf   = lane_ovf_q;
  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_packed_satadd_pipe.sv
// Bench for packed_satadd_pipe (4 lanes x 4 bits): vector table, scoreboard queue, stall/sticky/reset sequences.
module tb_packed_satadd_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op_sub;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  lane_ovf;
  logic [3:0]  sticky_ovf;
  logic        sticky_clr;

  packed_satadd_pipe #(.LANE_W(4), .LANES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op_sub     (op_sub),
    .sat_en     (sat_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .lane_ovf   (lane_ovf),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic        vsat;
    logic [15:0] eres;
    logic [3:0]  eovf;
  } vec_t;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [19:0] sb_q[$];
  logic [15:0] cur_res;
  logic [3:0]  cur_ovf;
  logic        mon_en     = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_res   = '0;
  logic        rand_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Independent reference: signed integer add/sub per lane, then clamp or truncate.
  function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic msub, input logic msat);
    logic [15:0] res;
    logic [3:0]  ovf;
    logic [3:0]  la, lb;
    int          sa, sbv, r;
    res = '0;
    ovf = '0;
    for (int i = 0; i < 4; i++) begin
      la  = ma[i*4 +: 4];
      lb  = mb[i*4 +: 4];
      sa  = int'($signed(la));
      sbv = int'($signed(lb));
      r   = msub ? sa - sbv : sa + sbv;
      ovf[i] = (r > 7) || (r < -8);
      if (ovf[i] && msat) res[i*4 +: 4] = (r > 0) ? 4'h7 : 4'h8;
      else                res[i*4 +: 4] = r[3:0];
    end
    return {ovf, res};
  endfunction

  // Scoreboard: push on input handshake, pop on output handshake; also checks output hold during stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", {16'd0, result}, {16'd0, prev_res});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          logic [19:0] e;
          e = sb_q.pop_front();
          chk("result", {16'd0, result}, {16'd0, e[15:0]});
          chk("lane_ovf", {28'd0, lane_ovf}, {28'd0, e[19:16]});
        end
      end
      if (in_valid && in_ready) sb_q.push_back({cur_ovf, cur_res});
      stall_prev = out_valid && !out_ready;
      prev_res   = result;
    end
  end

  task automatic send(input vec_t v);
    logic acc;
    int   n;
    a        = v.va;
    b        = v.vb;
    op_sub   = v.vsub;
    sat_en   = v.vsat;
    cur_res  = v.eres;
    cur_ovf  = v.eovf;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  task automatic pulse_clr();
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t strm[4];
  vec_t v;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h7777, 16'h1111, 1'b0, 1'b1, 16'h7777, 4'hF};
    tbl[1] = '{16'h7777, 16'h1111, 1'b0, 1'b0, 16'h8888, 4'hF};
    tbl[2] = '{16'h8888, 16'h8888, 1'b0, 1'b1, 16'h8888, 4'hF};
    tbl[3] = '{16'h8300, 16'h1580, 1'b1, 1'b1, 16'h8E70, 4'hA};
    tbl[4] = '{16'h8300, 16'h1580, 1'b1, 1'b0, 16'h7E80, 4'hA};
    tbl[5] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 4'h0};
    tbl[6] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'h000F, 4'h0};
    tbl[7] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFF0, 4'h0};
    tbl[8] = '{16'h7000, 16'hF000, 1'b1, 1'b1, 16'h7000, 4'h8};
    tbl[9] = '{16'h4C4C, 16'h4444, 1'b0, 1'b1, 16'h7070, 4'hA};

    strm[0] = '{16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 4'h0};
    strm[1] = '{16'h2222, 16'h1111, 1'b0, 1'b1, 16'h3333, 4'h0};
    strm[2] = '{16'h5555, 16'h1111, 1'b1, 1'b1, 16'h4444, 4'h0};
    strm[3] = '{16'h6666, 16'h3333, 1'b0, 1'b0, 16'h9999, 4'hF};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; sat_en = 1'b0;
    out_ready = 1'b1; sticky_clr = 1'b0; cur_res = '0; cur_ovf = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_lane_ovf", {28'd0, lane_ovf}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, valid after edge N+1.
    send(tbl[0]);
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_result", {16'd0, result}, 32'h7777);

    for (int i = 1; i < 10; i++) send(tbl[i]);
    drain();

    // Back-to-back stream with a 3-cycle output stall in the middle.
    fork
      for (int i = 0; i < 4; i++) send(strm[i]);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Sticky flags.
    pulse_clr();
    chk("sticky_clr_idle0", {28'd0, sticky_ovf}, 32'd0);
    v = '{16'h0007, 16'h0001, 1'b0, 1'b1, 16'h0007, 4'h1};
    send(v);
    v = '{16'h7000, 16'h1000, 1'b0, 1'b1, 16'h7000, 4'h8};
    send(v);
    drain();
    chk("sticky_accum", {28'd0, sticky_ovf}, 32'h9);
    v = '{16'h0070, 16'h0010, 1'b0, 1'b1, 16'h0070, 4'h2};
    send(v);
    pulse_clr();
    chk("sticky_clr_set", {28'd0, sticky_ovf}, 32'h2);
    drain();
    pulse_clr();
    chk("sticky_clr_only", {28'd0, sticky_ovf}, 32'h0);

    // Random mixed-mode traffic against the model with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [19:0] m;
          v.va   = 16'($urandom);
          v.vb   = 16'($urandom);
          v.vsub = 1'($urandom_range(1));
          v.vsat = 1'($urandom_range(1));
          m      = model(v.va, v.vb, v.vsub, v.vsat);
          v.eres = m[15:0];
          v.eovf = m[19:16];
          send(v);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with both stages full and the output stalled.
    pulse_clr();
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("sticky_pre_rst", {28'd0, sticky_ovf}, 32'hF);
    mon_en = 1'b0;
    sb_q.delete();
    stall_prev = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_result", {16'd0, result}, 32'd0);
    chk("arst_sticky", {28'd0, sticky_ovf}, 32'd0);
    chk("arst_lane_ovf", {28'd0, lane_ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_stale", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send(tbl[3]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
